track_buffer: RTL and testbench

Records the handwritten stroke for the digit-entry pad as a 28×28 cell bitmap. While the left mouse button is held over the 280×280-pixel drawing region, the cell under the cursor is set. The block sits directly upstream of `Vga_Top`: it produces `enable_track_display_out`, aligned to the VGA scan, and exports the flattened bitmap to the digit recogniser.

---
 rtl/vga_pkg.sv | 18 +
 rtl/track_scan_locator.sv | 78 +++++++
 rtl/track_buffer.sv | 149 ++++++++++++++
 tb/tb_track_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared drawing-pad constants, game state code and track buffer FSM encoding
package vga_pkg;

    localparam int TRK_X0   = 180;
    localparam int TRK_Y0   = 100;
    localparam int TRK_CELL = 10;
    localparam int TRK_N    = 28;

    localparam logic [1:0] SGAME = 2'd1;

    typedef enum logic [1:0] {
        TB_IDLE  = 2'd0,
        TB_DIV   = 2'd1,
        TB_WRITE = 2'd2,
        TB_CLEAR = 2'd3
    } trk_state_e;

endpackage

// File: rtl/track_scan_locator.sv
// rtl/track_scan_locator.sv - maps the VGA scan position onto drawing-region cell coordinates
module track_scan_locator
    import vga_pkg::*;
#(
    parameter int X0   = TRK_X0,
    parameter int Y0   = TRK_Y0,
    parameter int CELL = TRK_CELL,
    parameter int N    = TRK_N,
    parameter int CW   = $clog2(N)
) (
    input  logic          clka,
    input  logic          rst,
    input  logic [9:0]    h_cnt,
    input  logic [9:0]    v_cnt,
    output logic          in_region,
    output logic [CW-1:0] scan_row,
    output logic [CW-1:0] scan_col
);

    localparam int SW = (CELL > 1) ? $clog2(CELL) : 1;

    logic [SW-1:0] hsub_q, hsub_d, hsub_cur;
    logic [CW-1:0] col_q, col_d, col_cur;
    logic [SW-1:0] vsub_q, vsub_d;
    logic [CW-1:0] row_q, row_d;

    // The _cur values describe the pixel on h_cnt now; the registers hold the
    // prediction for the next pixel, so reloads take effect without a bubble.
    always_comb begin
        hsub_cur = hsub_q;
        col_cur  = col_q;
        if (h_cnt == 10'(X0)) begin
            hsub_cur = '0;
            col_cur  = '0;
        end
        if (hsub_cur == SW'(CELL - 1)) begin
            hsub_d = '0;
            col_d  = col_cur + CW'(1);
        end else begin
            hsub_d = hsub_cur + SW'(1);
            col_d  = col_cur;
        end

        vsub_d = vsub_q;
        row_d  = row_q;
        if (h_cnt == 10'd0) begin
            if (v_cnt == 10'(Y0)) begin
                vsub_d = '0;
                row_d  = '0;
            end else if (vsub_q == SW'(CELL - 1)) begin
                vsub_d = '0;
                row_d  = row_q + CW'(1);
            end else begin
                vsub_d = vsub_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            hsub_q <= '0;
            col_q  <= '0;
            vsub_q <= '0;
            row_q  <= '0;
        end else begin
            hsub_q <= hsub_d;
            col_q  <= col_d;
            vsub_q <= vsub_d;
            row_q  <= row_d;
        end
    end

    assign in_region = (h_cnt >= 10'(X0)) && (h_cnt < 10'(X0 + N * CELL)) &&
                       (v_cnt >= 10'(Y0)) && (v_cnt < 10'(Y0 + N * CELL));
    assign scan_row  = row_d;
    assign scan_col  = col_cur;

endmodule

// File: rtl/track_buffer.sv
// rtl/track_buffer.sv - 28x28 stroke bitmap with mouse write/clear FSM and VGA-aligned display output
module track_buffer
    import vga_pkg::*;
#(
    parameter int X0   = TRK_X0,
    parameter int Y0   = TRK_Y0,
    parameter int CELL = TRK_CELL,
    parameter int N    = TRK_N
) (
    input  logic           clka,
    input  logic           rst,
    input  logic           draw_en,
    input  logic           MOUSE_LEFT,
    input  logic [9:0]     mouse_x,
    input  logic [9:0]     mouse_y,
    input  logic           clear,
    input  logic [9:0]     h_cnt,
    input  logic [9:0]     v_cnt,
    output logic           enable_track_display_out,
    output logic [N*N-1:0] track_bits,
    output logic           busy
);

    localparam int CW = $clog2(N);
    localparam int IW = $clog2(N * N);

    trk_state_e     state_q, state_d;
    logic [9:0]     dx_q, dx_d, dy_q, dy_d;
    logic [CW-1:0]  col_q, col_d, row_q, row_d;
    logic [CW-1:0]  clr_row_q, clr_row_d;
    logic [N*N-1:0] bits_q, bits_d;
    logic [IW-1:0]  wr_idx, rd_idx;
    logic           mouse_in_region;
    logic           en_q, en_d;
    logic           scan_in_region;
    logic [CW-1:0]  scan_row, scan_col;

    assign mouse_in_region = (mouse_x >= 10'(X0)) && (mouse_x < 10'(X0 + N * CELL)) &&
                             (mouse_y >= 10'(Y0)) && (mouse_y < 10'(Y0 + N * CELL));

    assign wr_idx = IW'(row_q) * IW'(N) + IW'(col_q);

    // Cell index by repeated subtraction: one CELL step per axis per cycle.
    always_comb begin
        state_d   = state_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        col_d     = col_q;
        row_d     = row_q;
        clr_row_d = clr_row_q;
        bits_d    = bits_q;
        if (clear) begin
            state_d   = TB_CLEAR;
            clr_row_d = '0;
        end else begin
            case (state_q)
                TB_IDLE: begin
                    if (MOUSE_LEFT && draw_en && mouse_in_region) begin
                        dx_d    = mouse_x - 10'(X0);
                        dy_d    = mouse_y - 10'(Y0);
                        col_d   = '0;
                        row_d   = '0;
                        state_d = TB_DIV;
                    end
                end
                TB_DIV: begin
                    if ((dx_q < 10'(CELL)) && (dy_q < 10'(CELL))) begin
                        state_d = TB_WRITE;
                    end else begin
                        if (dx_q >= 10'(CELL)) begin
                            dx_d  = dx_q - 10'(CELL);
                            col_d = col_q + CW'(1);
                        end
                        if (dy_q >= 10'(CELL)) begin
                            dy_d  = dy_q - 10'(CELL);
                            row_d = row_q + CW'(1);
                        end
                    end
                end
                TB_WRITE: begin
                    bits_d[wr_idx] = 1'b1;
                    state_d        = TB_IDLE;
                end
                TB_CLEAR: begin
                    bits_d[IW'(clr_row_q) * IW'(N) +: N] = '0;
                    if (clr_row_q == CW'(N - 1)) begin
                        state_d = TB_IDLE;
                    end else begin
                        clr_row_d = clr_row_q + CW'(1);
                    end
                end
                default: state_d = TB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q   <= TB_IDLE;
            dx_q      <= '0;
            dy_q      <= '0;
            col_q     <= '0;
            row_q     <= '0;
            clr_row_q <= '0;
            bits_q    <= '0;
        end else begin
            state_q   <= state_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            col_q     <= col_d;
            row_q     <= row_d;
            clr_row_q <= clr_row_d;
            bits_q    <= bits_d;
        end
    end

    track_scan_locator #(
        .X0   (X0),
        .Y0   (Y0),
        .CELL (CELL),
        .N    (N),
        .CW   (CW)
    ) u_locator (
        .clka      (clka),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .in_region (scan_in_region),
        .scan_row  (scan_row),
        .scan_col  (scan_col)
    );

    // Reads the registered bitmap, so a same-cycle write shows up one pixel later.
    assign rd_idx = scan_in_region ? (IW'(scan_row) * IW'(N) + IW'(scan_col)) : '0;
    assign en_d   = scan_in_region & bits_q[rd_idx];

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_d;
        end
    end

    assign enable_track_display_out = en_q;
    assign track_bits               = bits_q;
    assign busy                     = (state_q != TB_IDLE);

endmodule

// File: tb/tb_track_buffer.sv
// tb/tb_track_buffer.sv - directed self-checking bench for track_buffer
module tb_track_buffer;

    localparam int X0   = 180;
    localparam int Y0   = 100;
    localparam int CELL = 10;
    localparam int N    = 28;

    logic           clka = 1'b0;
    logic           rst = 1'b1;
    logic           draw_en = 1'b0;
    logic           MOUSE_LEFT = 1'b0;
    logic           clear = 1'b0;
    logic [9:0]     mouse_x = '0;
    logic [9:0]     mouse_y = '0;
    logic [9:0]     h_cnt = '0;
    logic [9:0]     v_cnt = '0;
    logic           enable_track_display_out;
    logic           busy;
    logic [N*N-1:0] track_bits;
    logic [N*N-1:0] exp_bits;
    int             checks = 0;
    int             failures = 0;

    track_buffer dut (
        .clka                     (clka),
        .rst                      (rst),
        .draw_en                  (draw_en),
        .MOUSE_LEFT               (MOUSE_LEFT),
        .mouse_x                  (mouse_x),
        .mouse_y                  (mouse_y),
        .clear                    (clear),
        .h_cnt                    (h_cnt),
        .v_cnt                    (v_cnt),
        .enable_track_display_out (enable_track_display_out),
        .track_bits               (track_bits),
        .busy                     (busy)
    );

    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    function automatic logic exp_pix(input int h, input int v);
        if (h >= X0 && h < X0 + N * CELL && v >= Y0 && v < Y0 + N * CELL)
            return exp_bits[((v - Y0) / CELL) * N + (h - X0) / CELL];
        return 1'b0;
    endfunction

    // Lines outside [full_lo, full_hi] get only their h=0 pixel to keep the run short.
    task automatic scan(input int v_lo, input int v_hi, input int full_lo, input int full_hi);
        for (int v = v_lo; v <= v_hi; v++) begin
            int h_last;
            h_last = (v >= full_lo && v <= full_hi) ? 799 : 0;
            for (int h = 0; h <= h_last; h++) begin
                h_cnt = 10'(h);
                v_cnt = 10'(v);
                tick();
                check($sformatf("scan_en_x%0d_y%0d", h, v),
                      1024'(enable_track_display_out), 1024'(exp_pix(h, v)));
            end
        end
    endtask

    task automatic press(input int x, input int y, input int idx, input int lat);
        int   got;
        logic prev_busy, busy_at;
        mouse_x    = 10'(x);
        mouse_y    = 10'(y);
        draw_en    = 1'b1;
        MOUSE_LEFT = 1'b1;
        tick();
        MOUSE_LEFT = 1'b0;
        got       = -1;
        prev_busy = busy;
        busy_at   = busy;
        for (int k = 1; k <= 40 && got < 0; k++) begin
            tick();
            if (track_bits[idx]) begin
                got     = k;
                busy_at = busy;
            end else begin
                prev_busy = busy;
            end
        end
        check($sformatf("wr_latency_%0d", idx), 1024'(got), 1024'(lat));
        check($sformatf("wr_busy_before_%0d", idx), 1024'(prev_busy), 1024'(1'b1));
        check($sformatf("wr_busy_after_%0d", idx), 1024'(busy_at), 1024'(1'b0));
        exp_bits[idx] = 1'b1;
        check($sformatf("wr_bitmap_%0d", idx), 1024'(track_bits), 1024'(exp_bits));
    endtask

    task automatic press_none(input int x, input int y, input logic de);
        int bc;
        mouse_x    = 10'(x);
        mouse_y    = 10'(y);
        draw_en    = de;
        MOUSE_LEFT = 1'b1;
        tick();
        MOUSE_LEFT = 1'b0;
        draw_en    = 1'b1;
        bc = 0;
        for (int k = 0; k < 35; k++) begin
            if (busy) bc++;
            tick();
        end
        check($sformatf("nowrite_busy_x%0d_y%0d_en%0d", x, y, de), 1024'(bc), 1024'(0));
        check($sformatf("nowrite_bitmap_x%0d_y%0d_en%0d", x, y, de),
              1024'(track_bits), 1024'(exp_bits));
    endtask

    task automatic clear_run(input int second_at, input int exp_busy, input logic with_mouse);
        int bc;
        mouse_x    = 10'(185);
        mouse_y    = 10'(105);
        draw_en    = 1'b1;
        MOUSE_LEFT = with_mouse;
        clear      = 1'b1;
        tick();
        clear      = 1'b0;
        MOUSE_LEFT = 1'b0;
        bc = 0;
        for (int k = 0; k < 80; k++) begin
            if (!busy) break;
            bc++;
            clear = (k + 1 == second_at);
            tick();
        end
        clear    = 1'b0;
        exp_bits = '0;
        check($sformatf("clr_busy_cycles_%0d", second_at), 1024'(bc), 1024'(exp_busy));
        check($sformatf("clr_bitmap_%0d", second_at), 1024'(track_bits), 1024'(exp_bits));
    endtask

    initial begin
        int set_seen;
        exp_bits = '0;

        repeat (3) tick();
        check("rst_busy", 1024'(busy), 1024'(1'b0));
        check("rst_bitmap", 1024'(track_bits), 1024'(0));
        check("rst_enable", 1024'(enable_track_display_out), 1024'(1'b0));
        rst = 1'b0;
        tick();
        check("post_rst_busy", 1024'(busy), 1024'(1'b0));

        scan(0, 524, 95, 110);
        check("empty_bitmap", 1024'(track_bits), 1024'(0));

        press(185, 105, 0, 2);
        scan(90, 115, 98, 112);

        press_none(179, 105, 1'b1);
        press_none(460, 105, 1'b1);
        press_none(185, 105, 1'b0);

        press(459, 379, 783, 29);
        scan(95, 385, 368, 382);

        press(250, 200, 287, 12);
        press(300, 150, 152, 14);
        clear_run(0, 28, 1'b0);

        press(250, 200, 287, 12);
        press(185, 105, 0, 2);
        clear_run(10, 38, 1'b0);

        press(185, 105, 0, 2);
        clear_run(0, 28, 1'b1);

        // Clear lands while the (400,300) division is still running.
        mouse_x    = 10'(400);
        mouse_y    = 10'(300);
        draw_en    = 1'b1;
        MOUSE_LEFT = 1'b1;
        tick();
        MOUSE_LEFT = 1'b0;
        repeat (4) tick();
        check("div_busy", 1024'(busy), 1024'(1'b1));
        clear_run(0, 28, 1'b0);
        set_seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (track_bits[582]) set_seen++;
        end
        check("abort_bit582", 1024'(set_seen), 1024'(0));
        check("abort_busy", 1024'(busy), 1024'(1'b0));

        // Asynchronous reset mid-division wipes the bitmap without a clock edge.
        press(185, 105, 0, 2);
        mouse_x    = 10'(459);
        mouse_y    = 10'(379);
        MOUSE_LEFT = 1'b1;
        tick();
        MOUSE_LEFT = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_bitmap", 1024'(track_bits), 1024'(0));
        check("arst_busy", 1024'(busy), 1024'(1'b0));
        tick();
        rst      = 1'b0;
        exp_bits = '0;
        repeat (30) tick();
        check("arst_after_bitmap", 1024'(track_bits), 1024'(exp_bits));
        check("arst_after_busy", 1024'(busy), 1024'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
